prbs_checker: RTL and testbench
===============================

Name: prbs_checker

Overview:
- Bit-error-rate monitor directly downstream of the CDR loop. It consumes the recovered data bit (out_rx) in the clk_sys domain, qualified by the RX rising-edge clock enable.
- Seeds a local LFSR from the received stream, then verifies and locks.
- While locked, counts checked bits and bit errors, and drops lock on excessive errors.
- Results feed debug probes and testbench end-of-run BER reporting.

Parameters:
- PRBS_N, 7, LFSR length; must match the tx prbs generator.
- TAP_A, 7, first feedback tap (1-based).
- TAP_B, 6, second feedback tap (1-based); default polynomial x^7+x^6+1.
- LOCK_BITS, 64, consecutive correct predictions required in VERIFY before LOCKED.
- WIN_BITS, 256, loss-of-lock evaluation window, in checked bits.
- LOSS_THRESH, 16, errors within one window that force relock.
- CNT_WIDTH, 40, width of bit_count and err_count.

Ports:
- clk  input  1  clk_sys
- rst  input  1  synchronous active-high reset (driven by rst_rx_p)
- in_valid  input  1  bit strobe; tie to cke_rx_p
- in  input  1  recovered data bit (out_rx)
- clear  input  1  synchronous counter clear; state is unchanged
- locked  output  1  high in LOCKED state
- err_flag  output  1  one-cycle pulse, registered mismatch while LOCKED
- bit_count  output  CNT_WIDTH  bits checked while LOCKED (saturating)
- err_count  output  CNT_WIDTH  errors while LOCKED (saturating)
- relock_count  output  8  LOCKED->SEED transitions (saturating at 255)

Behaviour:
- One clock; reset is synchronous and active-high on clk/rst. All state updates occur only on cycles where in_valid=1, except reset and clear.
- Reset values: state=SEED; lfsr=0; locked=0; err_flag=0; all counters=0; seed/verify/window counters=0.
- Prediction: pred = lfsr[TAP_A-1] ^ lfsr[TAP_B-1]. Shift: lfsr <= {lfsr[PRBS_N-2:0], b}.
- SEED:
  - b = in; count PRBS_N valid bits, then go to VERIFY.
  - An all-zero lfsr after seeding returns to SEED (stuck-at guard).
- VERIFY:
  - b = in (self-synchronising).
  - in==pred increments the consecutive counter; a mismatch resets it to 0 and stays in VERIFY.
  - Counter reaching LOCK_BITS -> LOCKED.
  - No errors are counted in VERIFY.
- LOCKED:
  - b = pred (free-running), so a single channel error counts once rather than three times.
  - Each valid bit: bit_count += 1; on mismatch, err_count += 1 and err_flag=1 on the next clk.
  - Window counter wraps at WIN_BITS and clears the window error counter.
  - If window errors reach LOSS_THRESH: go to SEED, relock_count += 1, locked drops next cycle. Global counters are retained.
- Latency: locked and err_flag are registered, one clk after the in_valid cycle that causes them. err_flag is low on any cycle without a fresh mismatch.
- Saturation: counters hold at all-ones and never wrap.
- clear and mismatch in the same cycle: clear wins; counters=0 and err_flag still pulses.
- rst mid-operation: returns to SEED immediately; rst has priority over clear.
- in_valid on consecutive cycles is legal; in_valid may stay low for arbitrarily long with no state change.

Decomposition:
- Constants PRBS_N, TAP_A and TAP_B, plus typedef BER_COUNT_FORMAT (logic [CNT_WIDTH-1:0]), live in signal_package, shared with the prbs generator so the polynomials cannot diverge.
- Sub-module prbs_lfsr_pred: holds the lfsr register, takes a shift enable and the bit to shift in, and outputs pred. Its logic is reusable by prbs.
- The state machine and counters stay in prbs_checker.

Test Plan:
- Reset, then a clean PRBS7 stream with in_valid every 3rd clk -> locked rises exactly 7+64 valid bits after reset; err_count=0 after 10000 bits; bit_count = valid bits since lock.
- Locked, flip one bit -> err_flag single pulse one clk later; err_count=1 (not 3); locked stays 1.
- Locked, inject 16 errors within 256 bits -> locked=0 the clk after the 16th error; relock_count=1; relock after 71 further clean bits; err_count=16 retained.
- Inject 15 errors spread across a window boundary (8+7) -> no loss of lock.
- All-zero input stream -> never leaves SEED/VERIFY; locked stays 0.
- Preload err_count near all-ones via forced errors with CNT_WIDTH=4 -> saturates at 15. Assert clear with a simultaneous error -> counters 0 and err_flag=1. Assert rst while LOCKED -> all outputs 0 next clk.

Source files
------------

// File: rtl/signal_package.sv
// Shared PRBS constants and types for the prbs generator and checker, so the
// polynomials and count formats cannot diverge.
package signal_package;
    localparam int PRBS_N    = 7;
    localparam int TAP_A     = 7;
    localparam int TAP_B     = 6;
    localparam int CNT_WIDTH = 40;

    typedef logic [CNT_WIDTH-1:0] BER_COUNT_FORMAT;

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } chk_state_e;
endpackage

// File: rtl/prbs_checker_if.sv
// Bit stream in, lock status and BER counters out.
interface prbs_checker_if #(
    parameter int CNT_WIDTH = signal_package::CNT_WIDTH
);
    logic                 in_valid;
    logic                 in;
    logic                 clear;
    logic                 locked;
    logic                 err_flag;
    logic [CNT_WIDTH-1:0] bit_count;
    logic [CNT_WIDTH-1:0] err_count;
    logic [7:0]           relock_count;

    modport master (
        output in_valid, in, clear,
        input  locked, err_flag, bit_count, err_count, relock_count
    );
    modport slave (
        input  in_valid, in, clear,
        output locked, err_flag, bit_count, err_count, relock_count
    );
endinterface

// File: rtl/prbs_lfsr_pred.sv
// Fibonacci LFSR history register with next-bit prediction; shared with the
// prbs generator.
module prbs_lfsr_pred #(
    parameter int N     = signal_package::PRBS_N,
    parameter int TAP_A = signal_package::TAP_A,
    parameter int TAP_B = signal_package::TAP_B
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic din,
    output logic pred,
    output logic nxt_zero
);
    logic [N-1:0] lfsr;

    always_ff @(posedge clk) begin
        if (rst)     lfsr <= '0;
        else if (en) lfsr <= {lfsr[N-2:0], din};
    end

    assign pred     = lfsr[TAP_A-1] ^ lfsr[TAP_B-1];
    // Would the register be all-zero after shifting din in this cycle
    assign nxt_zero = ({lfsr[N-2:0], din} == '0);
endmodule

// File: rtl/prbs_checker.sv
// PRBS bit-error-rate checker: seeds from the stream, verifies, then counts
// checked bits and errors while locked, relocking on excessive window errors.
module prbs_checker #(
    parameter int PRBS_N      = signal_package::PRBS_N,
    parameter int TAP_A       = signal_package::TAP_A,
    parameter int TAP_B       = signal_package::TAP_B,
    parameter int LOCK_BITS   = 64,
    parameter int WIN_BITS    = 256,
    parameter int LOSS_THRESH = 16,
    parameter int CNT_WIDTH   = signal_package::CNT_WIDTH
) (
    input logic           clk,
    input logic           rst,
    prbs_checker_if.slave bus
);
    import signal_package::*;

    localparam int SW = $clog2(PRBS_N + 1);
    localparam int VW = $clog2(LOCK_BITS + 1);
    localparam int WW = $clog2(WIN_BITS);
    localparam int EW = $clog2(LOSS_THRESH + 1);

    chk_state_e           state_q, state_d;
    logic [SW-1:0]        seed_cnt_q;
    logic [VW-1:0]        ver_cnt_q;
    logic [WW-1:0]        win_cnt_q;
    logic [EW-1:0]        win_err_q, win_err_inc;
    logic                 err_flag_q;
    logic [CNT_WIDTH-1:0] bit_cnt_q, err_cnt_q;
    logic [7:0]           relock_q;
    logic pred, nxt_zero, shift_bit, mismatch, ver_hit;
    logic seed_done, lock_hit, loss, win_wrap;

    prbs_lfsr_pred #(.N(PRBS_N), .TAP_A(TAP_A), .TAP_B(TAP_B)) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .en       (bus.in_valid),
        .din      (shift_bit),
        .pred     (pred),
        .nxt_zero (nxt_zero)
    );

    // While locked the LFSR free-runs on its own prediction, so one channel
    // error is counted once instead of echoing through both taps.
    always_comb begin
        shift_bit   = (state_q == ST_LOCKED) ? pred : bus.in;
        mismatch    = bus.in_valid && (state_q == ST_LOCKED) && (bus.in != pred);
        ver_hit     = (bus.in == pred);
        seed_done   = (seed_cnt_q == SW'(PRBS_N - 1));
        lock_hit    = ver_hit && (ver_cnt_q == VW'(LOCK_BITS - 1));
        win_err_inc = win_err_q + EW'(mismatch);
        loss        = mismatch && (win_err_inc == EW'(LOSS_THRESH));
        win_wrap    = (win_cnt_q == WW'(WIN_BITS - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_SEED;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.in_valid) begin
            case (state_q)
                ST_SEED:   if (seed_done && !nxt_zero) state_d = ST_VERIFY;
                ST_VERIFY: if (lock_hit)               state_d = ST_LOCKED;
                ST_LOCKED: if (loss)                   state_d = ST_SEED;
                default:                               state_d = ST_SEED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seed_cnt_q <= '0;
            ver_cnt_q  <= '0;
            win_cnt_q  <= '0;
            win_err_q  <= '0;
            err_flag_q <= 1'b0;
            bit_cnt_q  <= '0;
            err_cnt_q  <= '0;
            relock_q   <= '0;
        end else begin
            err_flag_q <= mismatch;
            if (bus.in_valid) begin
                case (state_q)
                    ST_SEED: begin
                        seed_cnt_q <= seed_done ? '0 : seed_cnt_q + SW'(1);
                        ver_cnt_q  <= '0;
                    end
                    ST_VERIFY: begin
                        ver_cnt_q <= (ver_hit && !lock_hit) ? ver_cnt_q + VW'(1) : '0;
                        win_cnt_q <= '0;
                        win_err_q <= '0;
                    end
                    ST_LOCKED: begin
                        win_cnt_q <= win_wrap ? '0 : win_cnt_q + WW'(1);
                        win_err_q <= (win_wrap || loss) ? '0 : win_err_inc;
                    end
                    default: seed_cnt_q <= '0;
                endcase
            end
            // Clear beats any same-cycle increment; err_flag is unaffected.
            if (bus.clear) begin
                bit_cnt_q <= '0;
                err_cnt_q <= '0;
                relock_q  <= '0;
            end else if (bus.in_valid && state_q == ST_LOCKED) begin
                if (bit_cnt_q != '1)            bit_cnt_q <= bit_cnt_q + CNT_WIDTH'(1);
                if (mismatch && err_cnt_q != '1) err_cnt_q <= err_cnt_q + CNT_WIDTH'(1);
                if (loss && relock_q != 8'hFF)   relock_q  <= relock_q + 8'd1;
            end
        end
    end

    always_comb begin
        bus.locked       = (state_q == ST_LOCKED);
        bus.err_flag     = err_flag_q;
        bus.bit_count    = bit_cnt_q;
        bus.err_count    = err_cnt_q;
        bus.relock_count = relock_q;
    end
endmodule

// File: tb/tb_prbs_checker.sv
// Randomised PRBS7 stream against a behavioural BER model; two DUTs (40-bit and
// 4-bit counters) share the stimulus so saturation is exercised too.
module tb_prbs_checker;
    localparam int PRBS_N = 7, TAP_A = 7, TAP_B = 6;
    localparam int LOCK_BITS = 64, WIN_BITS = 256, LOSS = 16;
    localparam int M_SEED = 0, M_VER = 1, M_LOCK = 2;

    logic clk = 1'b0;
    logic rst, in_valid, din, clear;
    always #5 clk = ~clk;

    prbs_checker_if #(.CNT_WIDTH(40)) bus40 ();
    prbs_checker_if #(.CNT_WIDTH(4))  bus4 ();
    assign bus40.in_valid = in_valid;
    assign bus40.in       = din;
    assign bus40.clear    = clear;
    assign bus4.in_valid  = in_valid;
    assign bus4.in        = din;
    assign bus4.clear     = clear;

    prbs_checker #(.CNT_WIDTH(40)) u40 (.clk(clk), .rst(rst), .bus(bus40));
    prbs_checker #(.CNT_WIDTH(4))  u4  (.clk(clk), .rst(rst), .bus(bus4));

    int errs = 0, checks = 0;

    // behavioural model state
    int     m_mode, m_nseed, m_nver, m_nchk, m_werr;
    longint c_bit, c_err, c_rel;
    bit     m_flag;
    bit     m_q[$];
    bit [6:0] g = 7'h7F;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] satw(input longint c, input int w);
        logic [63:0] mx;
        mx = (64'd1 << w) - 64'd1;
        return (64'(c) > mx) ? mx : 64'(c);
    endfunction

    function automatic bit gold_next();
        bit b;
        b = g[6] ^ g[5];
        g = {g[5:0], b};
        return b;
    endfunction

    task automatic model_reset();
        m_mode = M_SEED; m_nseed = 0; m_nver = 0; m_nchk = 0; m_werr = 0;
        c_bit = 0; c_err = 0; c_rel = 0; m_flag = 0;
        m_q = {};
        repeat (PRBS_N) m_q.push_back(1'b0);
    endtask

    task automatic model_step();
        bit pred, allz;
        if (rst) begin
            model_reset();
            return;
        end
        m_flag = 0;
        if (in_valid) begin
            // m_q[0] is the oldest of the last PRBS_N effective bits
            pred = m_q[PRBS_N - TAP_A] ^ m_q[PRBS_N - TAP_B];
            case (m_mode)
                M_SEED: begin
                    m_q.push_back(din); void'(m_q.pop_front());
                    m_nseed++;
                    if (m_nseed == PRBS_N) begin
                        m_nseed = 0;
                        allz = 1;
                        foreach (m_q[i]) if (m_q[i]) allz = 0;
                        if (!allz) begin m_mode = M_VER; m_nver = 0; end
                    end
                end
                M_VER: begin
                    m_q.push_back(din); void'(m_q.pop_front());
                    m_nver = (din == pred) ? m_nver + 1 : 0;
                    if (m_nver == LOCK_BITS) begin m_mode = M_LOCK; m_nchk = 0; m_werr = 0; end
                end
                default: begin
                    m_q.push_back(pred); void'(m_q.pop_front());
                    c_bit++;
                    if (din != pred) begin c_err++; m_flag = 1; m_werr++; end
                    m_nchk++;
                    if (m_werr == LOSS) begin m_mode = M_SEED; m_nseed = 0; c_rel++; end
                    else if (m_nchk % WIN_BITS == 0) m_werr = 0;
                end
            endcase
        end
        if (clear) begin c_bit = 0; c_err = 0; c_rel = 0; end
    endtask

    // Compare outputs each negedge, then advance the model with the inputs the
    // DUT will sample on the coming posedge.
    initial begin
        model_reset();
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("locked40", 64'(bus40.locked),   64'(m_mode == M_LOCK));
            chk("flag40",   64'(bus40.err_flag), 64'(m_flag));
            chk("bits40",   64'(bus40.bit_count), satw(c_bit, 40));
            chk("errs40",   64'(bus40.err_count), satw(c_err, 40));
            chk("relock40", 64'(bus40.relock_count), satw(c_rel, 8));
            chk("locked4",  64'(bus4.locked),    64'(m_mode == M_LOCK));
            chk("flag4",    64'(bus4.err_flag),  64'(m_flag));
            chk("bits4",    64'(bus4.bit_count), satw(c_bit, 4));
            chk("errs4",    64'(bus4.err_count), satw(c_err, 4));
            chk("relock4",  64'(bus4.relock_count), satw(c_rel, 8));
            model_step();
        end
    end

    // One valid bit then gap idle cycles; starts and ends at posedge+1.
    task automatic send_raw(input bit b, input bit c, input int gap);
        in_valid = 1'b1; din = b; clear = c;
        @(posedge clk); #1;
        in_valid = 1'b0; clear = 1'b0; din = 1'($urandom);
        repeat (gap) begin @(posedge clk); #1; end
    endtask

    task automatic send(input bit e, input bit c, input int gap);
        bit b;
        b = gold_next();
        send_raw(b ^ e, c, gap);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; din = 1'b0; clear = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_locked", 64'(bus40.locked), 64'd0);
        chk("rst_bits",   64'(bus40.bit_count), 64'd0);

        // clean stream, valid every third clock: lock after exactly 7+64 bits
        for (int i = 1; i <= 71; i++) begin
            send(0, 0, 2);
            if (i == 70) chk("lock_early", 64'(bus40.locked), 64'd0);
        end
        chk("lock_at_71", 64'(bus40.locked), 64'd1);
        chk("model_lock71", 64'(m_mode == M_LOCK), 64'd1);
        for (int i = 0; i < 9929; i++) send(0, 0, 2);
        chk("clean_errs", 64'(bus40.err_count), 64'd0);
        chk("clean_bits", 64'(bus40.bit_count), 64'd9929);

        // single flipped bit: one pulse, one count
        send(1, 0, 0);
        chk("flag_pulse", 64'(bus40.err_flag), 64'd1);
        chk("err_once",   64'(bus40.err_count), 64'd1);
        send(0, 0, 0);
        chk("flag_drop",  64'(bus40.err_flag), 64'd0);
        chk("still_lock", 64'(bus40.locked), 64'd1);

        // clear, then 16 errors inside one window
        send(0, 1, 1);
        chk("clear_bits", 64'(bus40.bit_count), 64'd0);
        for (int i = 0; i < 300 && (m_nchk % WIN_BITS) != 0; i++) send(0, 0, 0);
        for (int k = 0; k <= 60; k++) begin
            send(k % 4 == 0, 0, 1);
            if (k == 56) chk("lock_at_15", 64'(bus40.locked), 64'd1);
        end
        chk("loss_lock",  64'(bus40.locked), 64'd0);
        chk("relock_1",   64'(bus40.relock_count), 64'd1);
        chk("model_rel",  64'(c_rel), 64'd1);
        for (int i = 1; i <= 71; i++) begin
            send(0, 0, 1);
            if (i == 70) chk("relock_early", 64'(bus40.locked), 64'd0);
        end
        chk("relocked",   64'(bus40.locked), 64'd1);
        chk("err_kept",   64'(bus40.err_count), 64'd16);

        // 8 + 7 errors straddling a window boundary: lock must hold
        for (int i = 0; i < 300 && (m_nchk % WIN_BITS) != WIN_BITS - 8; i++) send(0, 0, 0);
        for (int k = 0; k < 15; k++) send(1, 0, 0);
        for (int k = 0; k < 20; k++) send(0, 0, 0);
        chk("straddle_lock", 64'(bus40.locked), 64'd1);
        chk("straddle_rel",  64'(bus40.relock_count), 64'd1);
        chk("straddle_errs", 64'(bus40.err_count), 64'd31);

        // random gaps, errors and clears
        for (int i = 0; i < 3000; i++)
            send($urandom_range(0, 29) == 0, $urandom_range(0, 499) == 0, $urandom_range(0, 2));

        // saturation of the 4-bit instance
        for (int i = 0; i < 300 && m_mode != M_LOCK; i++) send(0, 0, 0);
        chk("pre_sat_lock", 64'(bus40.locked), 64'd1);
        send(0, 1, 0);
        for (int k = 0; k < 400; k++) send(k % 20 == 0, 0, 0);
        chk("sat_errs4",  64'(bus4.err_count), 64'd15);
        chk("sat_bits4",  64'(bus4.bit_count), 64'd15);
        chk("errs40_20",  64'(bus40.err_count), 64'd20);
        chk("bits40_400", 64'(bus40.bit_count), 64'd400);

        // clear together with an error
        send(1, 1, 0);
        chk("clr_err_flag", 64'(bus4.err_flag), 64'd1);
        chk("clr_err_cnt",  64'(bus4.err_count), 64'd0);
        chk("clr_bit_cnt",  64'(bus40.bit_count), 64'd0);

        // reset while locked
        chk("pre_rst_lock", 64'(bus40.locked), 64'd1);
        rst = 1'b1; in_valid = 1'b1; din = 1'b1; clear = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        chk("rst_lock0", 64'(bus40.locked), 64'd0);
        chk("rst_flag0", 64'(bus40.err_flag), 64'd0);
        chk("rst_rel0",  64'(bus40.relock_count), 64'd0);

        // all-zero stream never locks, then a real stream recovers
        for (int i = 0; i < 300; i++) send_raw(1'b0, 1'b0, $urandom_range(0, 1));
        chk("zero_nolock", 64'(bus40.locked), 64'd0);
        for (int i = 0; i < 200; i++) send(0, 0, 0);
        chk("post_zero_lock", 64'(bus40.locked), 64'd1);

        repeat (3) @(posedge clk);
        #1 $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
